// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and coefficient type.
package ntt_pkg;

  localparam int          NB_BIT_Q    = 23;
  localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

  typedef logic [NB_BIT_Q-1:0] coef_t;

endpackage

// File: rtl/subtractor_n.sv
// Plain n-bit combinational subtractor; the MSB of the result acts as borrow
// when callers zero-extend their operands by one bit.
module subtractor_n #(
  parameter int nb_bit = 24
) (
  input  logic [nb_bit-1:0] a,
  input  logic [nb_bit-1:0] b,
  output logic [nb_bit-1:0] diff
);

  assign diff = a - b;

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor c = (a - b) mod q with valid/ready
// flow control and a tag carried alongside each operand pair.
module mod_sub_pipe
  import ntt_pkg::*;
#(
  parameter int NB_BIT = NB_BIT_Q,
  parameter int TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NB_BIT-1:0] q_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [NB_BIT-1:0] a_i,
  input  logic [NB_BIT-1:0] b_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [NB_BIT-1:0] c_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 (output register) valid
  logic [2:1]        vld_pipe;
  logic              s1_adv, s2_adv, in_fire;
  logic [NB_BIT:0]   diff_full;
  logic [NB_BIT-1:0] s1_diff;
  logic              s1_borrow;
  logic [TAG_W-1:0]  s1_tag;
  logic [NB_BIT-1:0] c_nxt;

  assign s2_adv     = !vld_pipe[2] | out_ready_i;
  assign s1_adv     = !vld_pipe[1] | s2_adv;
  assign in_ready_o = s1_adv;
  assign in_fire    = in_valid_i & s1_adv;

  subtractor_n #(.nb_bit(NB_BIT + 1)) u_sub (
    .a    ({1'b0, a_i}),
    .b    ({1'b0, b_i}),
    .diff (diff_full)
  );

  // Adding q back to the wrapped difference lands in [0, q) for legal inputs.
  assign c_nxt = s1_borrow ? (s1_diff + q_i) : s1_diff;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe  <= '0;
      s1_diff   <= '0;
      s1_borrow <= 1'b0;
      s1_tag    <= '0;
      c_o       <= '0;
      tag_o     <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_fire;
        if (in_fire) begin
          s1_diff   <= diff_full[NB_BIT-1:0];
          s1_borrow <= diff_full[NB_BIT];
          s1_tag    <= tag_i;
        end
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          c_o   <= c_nxt;
          tag_o <= s1_tag;
        end
      end
    end
  end

  assign out_valid_o = vld_pipe[2];
  assign busy_o      = |vld_pipe;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed and scoreboarded checks of the pipelined modular subtractor.
module tb_mod_sub_pipe;

  localparam int          NB = 23;
  localparam int          TW = 8;
  localparam logic [22:0] Q  = 23'd8380417;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] q = Q;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic [TW-1:0] tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] c;
  logic [TW-1:0] tag_out;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NB-1:0] exp_c_q[$];
  logic [TW-1:0] exp_t_q[$];

  always #5 clk = ~clk;

  mod_sub_pipe #(.NB_BIT(NB), .TAG_W(TW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .q_i         (q),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  function automatic logic [NB-1:0] model(input logic [NB-1:0] x, input logic [NB-1:0] y);
    int unsigned r;
    r = (32'(x) + 32'(Q) - 32'(y)) % 32'(Q);
    return r[NB-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (c !== '0) $display("FAIL rst_c got %0d want 0", c); else n_pass++;
    n_checks++; if (tag_out !== '0) $display("FAIL rst_tag got %0d want 0", tag_out); else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [NB-1:0] av[2];
    logic [NB-1:0] bv[2];
    logic [NB-1:0] ev[2];
    av[0] = 23'd5; bv[0] = 23'd3; ev[0] = 23'd2;
    av[1] = 23'd3; bv[1] = 23'd5; ev[1] = 23'd8380415;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = av[i]; b = bv[i]; tag = 8'h10 + 8'(i); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_lat1 got %b want 0", out_valid); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_lat2 got %b want 1", out_valid); else n_pass++;
      n_checks++; if (c !== ev[i]) $display("FAIL basic_c got %0d want %0d", c, ev[i]); else n_pass++;
      n_checks++; if (tag_out !== 8'h10 + 8'(i)) $display("FAIL basic_tag got %0d want %0d", tag_out, 8'h10 + 8'(i)); else n_pass++;
      tick();
    end
  endtask

  task automatic test_edges();
    logic [NB-1:0] av[4];
    logic [NB-1:0] bv[4];
    logic [NB-1:0] ev[4];
    av[0] = 23'd0;       bv[0] = 23'd0;       ev[0] = 23'd0;
    av[1] = 23'd0;       bv[1] = 23'd8380416; ev[1] = 23'd1;
    av[2] = 23'd8380416; bv[2] = 23'd0;       ev[2] = 23'd8380416;
    av[3] = 23'd8380416; bv[3] = 23'd8380416; ev[3] = 23'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = av[i]; b = bv[i]; tag = 8'h20 + 8'(i); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || c !== ev[i] || tag_out !== 8'h20 + 8'(i))
        $display("FAIL edge%0d got v=%b c=%0d tag=%0d want v=1 c=%0d tag=%0d",
                 i, out_valid, c, tag_out, ev[i], 8'h20 + 8'(i));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int rcv = 0;
    int not_ready = 0;
    logic [NB-1:0] ec;
    logic [TW-1:0] et;
    exp_c_q.delete(); exp_t_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 1010; i++) begin
      if (i < 1000) begin
        a = NB'($urandom_range(0, 8380416));
        b = NB'($urandom_range(0, 8380416));
        tag = 8'(i);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (i == 1) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_lat1 got %b want 0", out_valid); else n_pass++;
      end
      if (i == 2) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_lat2 got %b want 1", out_valid); else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_c_q.size() == 0) $display("FAIL b2b_extra got c=%0d want none", c);
        else begin
          ec = exp_c_q.pop_front(); et = exp_t_q.pop_front();
          if (c !== ec || tag_out !== et)
            $display("FAIL b2b_data got c=%0d tag=%0d want c=%0d tag=%0d", c, tag_out, ec, et);
          else n_pass++;
        end
        rcv++;
      end
      if (in_valid) begin
        if (in_ready) begin exp_c_q.push_back(model(a, b)); exp_t_q.push_back(tag); end
        else not_ready++;
      end
      tick();
    end
    n_checks++; if (rcv !== 1000) $display("FAIL b2b_count got %0d want 1000", rcv); else n_pass++;
    n_checks++; if (not_ready !== 0) $display("FAIL b2b_stalls got %0d want 0", not_ready); else n_pass++;
  endtask

  task automatic test_stall();
    int idx = 0;
    int rcv = 0;
    logic [NB-1:0] ec;
    logic [TW-1:0] et;
    exp_c_q.delete(); exp_t_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      a = NB'(1000 + idx); b = 23'd2000; tag = 8'hA0 + 8'(idx); in_valid = 1'b1;
      #1;
      if (k >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || c !== 23'd8379417 || tag_out !== 8'hA0 || in_ready !== 1'b0)
          $display("FAIL stall_hold got v=%b c=%0d tag=%0d rdy=%b want v=1 c=8379417 tag=160 rdy=0",
                   out_valid, c, tag_out, in_ready);
        else n_pass++;
      end
      if (in_ready) begin exp_c_q.push_back(model(a, b)); exp_t_q.push_back(tag); idx++; end
      tick();
    end
    n_checks++; if (idx !== 2) $display("FAIL stall_accepted got %0d want 2", idx); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_c_q.size() == 0) $display("FAIL stall_extra got c=%0d want none", c);
        else begin
          ec = exp_c_q.pop_front(); et = exp_t_q.pop_front();
          if (c !== ec || tag_out !== et)
            $display("FAIL stall_drain got c=%0d tag=%0d want c=%0d tag=%0d", c, tag_out, ec, et);
          else n_pass++;
        end
        rcv++;
      end
      tick();
    end
    n_checks++; if (rcv !== 2) $display("FAIL stall_released got %0d want 2", rcv); else n_pass++;
  endtask

  task automatic test_random();
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    logic [NB-1:0] ec;
    logic [TW-1:0] et;
    exp_c_q.delete(); exp_t_q.delete();
    while ((sent < 300 || exp_c_q.size() != 0) && cyc < 5000) begin
      in_valid  = (sent < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      a = NB'($urandom_range(0, 8380416));
      b = NB'($urandom_range(0, 8380416));
      tag = 8'(sent);
      #1;
      n_checks++;
      if (busy !== (exp_c_q.size() != 0))
        $display("FAIL rnd_busy got %b want %b", busy, exp_c_q.size() != 0);
      else n_pass++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_c_q.size() == 0) $display("FAIL rnd_extra got c=%0d want none", c);
        else begin
          ec = exp_c_q.pop_front(); et = exp_t_q.pop_front();
          if (c !== ec || tag_out !== et)
            $display("FAIL rnd_data got c=%0d tag=%0d want c=%0d tag=%0d", c, tag_out, ec, et);
          else n_pass++;
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_c_q.push_back(model(a, b)); exp_t_q.push_back(tag); sent++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (rcv !== 300) $display("FAIL rnd_count got %0d want 300 (cycles %0d)", rcv, cyc); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    exp_c_q.delete(); exp_t_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = NB'(50 + i); b = 23'd7; tag = 8'hC0 + 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL mid_full got v=%b busy=%b want 1 1", out_valid, busy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", busy); else n_pass++;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL mid_after got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
